// File: rtl/pulse_burst_decoder.sv
// pulse_burst_decoder
//   Samples an asynchronous pulse line, groups rising edges into bursts and
//   reports each completed burst's pulse count and longest high time.
//
// Ports
//   clock       : single clock, everything on posedge
//   reset       : asynchronous, active-high; clears all state and outputs
//   signal      : asynchronous pulse line under observation
//   burst_valid : one-cycle strobe when a burst has completed
//   burst_count : pulses in the last completed burst (saturates at 2^CNT_W-1)
//   max_width   : longest high time in the last completed burst, in cycles
//   overflow    : last completed burst's pulse count saturated
//   busy        : FSM is not idle
module pulse_burst_decoder #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned WIDTH_W     = 8,
  parameter int unsigned IDLE_CYCLES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               signal,
  output logic               burst_valid,
  output logic [CNT_W-1:0]   burst_count,
  output logic [WIDTH_W-1:0] max_width,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  localparam logic [WIDTH_W-1:0] GAP_LAST = WIDTH_W'(IDLE_CYCLES - 1);

  state_t               state, state_n;
  logic                 s1, s2;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [WIDTH_W-1:0]   width, width_n;
  logic [WIDTH_W-1:0]   maxw, maxw_n;
  logic [WIDTH_W-1:0]   gap, gap_n;
  logic                 ovf, ovf_n;
  logic                 burst_valid_n;
  logic [CNT_W-1:0]     burst_count_n;
  logic [WIDTH_W-1:0]   max_width_n;
  logic                 overflow_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      width       <= '0;
      maxw        <= '0;
      gap         <= '0;
      ovf         <= 1'b0;
      burst_valid <= 1'b0;
      burst_count <= '0;
      max_width   <= '0;
      overflow    <= 1'b0;
    end else begin
      s1          <= signal;
      s2          <= s1;
      state       <= state_n;
      cnt         <= cnt_n;
      width       <= width_n;
      maxw        <= maxw_n;
      gap         <= gap_n;
      ovf         <= ovf_n;
      burst_valid <= burst_valid_n;
      burst_count <= burst_count_n;
      max_width   <= max_width_n;
      overflow    <= overflow_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    width_n       = width;
    maxw_n        = maxw;
    gap_n         = gap;
    ovf_n         = ovf;
    burst_valid_n = 1'b0;
    burst_count_n = burst_count;
    max_width_n   = max_width;
    overflow_n    = overflow;
    case (state)
      IDLE: begin
        if (s2) begin
          state_n = HIGH;
          cnt_n   = CNT_W'(1);
          width_n = WIDTH_W'(1);
          maxw_n  = '0;
          gap_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      HIGH: begin
        if (s2) begin
          if (width != '1) width_n = width + WIDTH_W'(1);
        end else begin
          state_n = GAP;
          maxw_n  = (width > maxw) ? width : maxw;
          gap_n   = WIDTH_W'(1);
        end
      end
      GAP: begin
        if (s2) begin
          state_n = HIGH;
          width_n = WIDTH_W'(1);
          gap_n   = '0;
          if (cnt == '1) ovf_n = 1'b1;
          else           cnt_n = cnt + CNT_W'(1);
        end else if (gap == GAP_LAST) begin
          state_n       = IDLE;
          burst_valid_n = 1'b1;
          burst_count_n = cnt;
          max_width_n   = maxw;
          overflow_n    = ovf;
        end else begin
          gap_n = gap + WIDTH_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/pulse_burst_decoder.md
# pulse_burst_decoder

Receive-side counterpart of the clocked pulse and burst generators in the Guia_09 clock test set. It samples an asynchronous `signal` line on `clock` and groups rising edges into bursts. A burst ends after a fixed low-time gap; at that point the block reports how many pulses the burst contained and the longest high time among them. Test benches use it to check generator output automatically instead of by eye in the VCD.

## Interface
- `CNT_W`, default 4: width of the pulse counter; counts saturate at 2^CNT_W-1.
- `WIDTH_W`, default 8: width of the high-time counters; high time saturates at 2^WIDTH_W-1.
- `IDLE_CYCLES`, default 8: number of consecutive low samples that terminates a burst. Legal range is 2 to 2^WIDTH_W-1.
- `clock` in 1: single clock. Everything is on the posedge.
- `reset` in 1: asynchronous, active-high. Clears all state and outputs immediately.
- `signal` in 1: asynchronous pulse line under observation.
- `burst_valid` out 1: one-cycle strobe when a burst has completed.
- `burst_count` out CNT_W: number of pulses in the last completed burst.
- `max_width` out WIDTH_W: longest high time in the last completed burst, in clock cycles.
- `overflow` out 1: set when the last burst's pulse count saturated.
- `busy` out 1: high while the FSM is not in IDLE.

## Operation
- Input path: two-flop synchronizer, `signal` -> `s1` -> `s2`. The FSM acts on `s2` only. One "sample" means the `s2` value seen at one posedge.
- State machine: IDLE, HIGH, GAP.
  - IDLE with a sample of 1: go to HIGH. Set cnt=1, width=1, maxw=0.
  - HIGH with a sample of 1: width = width+1, saturating.
  - HIGH with a sample of 0: go to GAP. Set maxw = max(maxw, width) and gap=1.
  - GAP with a sample of 1: go to HIGH. Set width=1 and gap=0. Set cnt = cnt+1, saturating; if cnt is already at its maximum, set the internal ovf.
  - GAP with a sample of 0 and gap < IDLE_CYCLES-1: gap = gap+1.
  - GAP with a sample of 0 and gap == IDLE_CYCLES-1: go to IDLE. Register the outputs: burst_valid=1, burst_count=cnt, max_width=maxw, overflow=ovf.
- Output holding: `burst_count`, `max_width` and `overflow` hold their values until the next completion strobe. `burst_valid` is high for exactly one cycle per burst.
- Boundary: a gap of IDLE_CYCLES-1 low samples keeps the burst open. A gap of IDLE_CYCLES low samples closes it.
- Boundary: a pulse whose rise falls in the same cycle as a completion strobe cannot occur, because the FSM is in GAP with a low sample. The next high sample in IDLE starts a new burst on the cycle after the strobe.
- `signal` held high indefinitely: the FSM stays in HIGH, width saturates, and no strobe is issued.
- `reset` asserted mid-burst: state returns to IDLE, all counters clear, and no strobe is issued. The partial burst is discarded.
- Reset values: `burst_valid`=0, `burst_count`=0, `max_width`=0, `overflow`=0, `busy`=0, and both synchronizer flops =0.

## Timing
- Input latency: 2 edges from `signal` to `s2`. A level on `signal` captured at edge k is acted on by the FSM at edge k+2.
- High-time accuracy: a pulse captured high at N consecutive edges measures width N.
- Completion latency: let f be the first edge at which the final fall of `signal` is captured. `burst_valid` is registered at edge f+IDLE_CYCLES+1 and is high for the following cycle.
- Busy window: `busy` rises at the edge where the FSM enters HIGH. It falls at the same edge where `burst_valid` rises.
- Minimum pulse: a pulse must be high for at least one clock period to be guaranteed a capture. Shorter pulses may be missed, and missing them is acceptable.

## Test plan
- Single pulse: `signal` high for 3 clock periods, then low. Required: one strobe with burst_count=1, max_width=3, overflow=0, at edge f+9 (IDLE_CYCLES=8).
- Burst of 6: high 2 cycles / low 2 cycles, six times, then low. Required: one strobe with burst_count=6, max_width=2.
- Gap boundary: pulse, 7 low cycles, pulse, then idle. Required: one strobe with count 2. Repeat with an 8-cycle gap: required two strobes, each with count 1.
- Saturation: 17 pulses, each 1 high / 1 low. Required: burst_count=15, overflow=1. The next 1-pulse burst reports overflow=0.
- Width: pulses of 1, 5 and 3 cycles in one burst. Required: max_width=5. `signal` stuck high for 300 cycles: required busy=1, no strobe.
- Reset: assert `reset` during the 4th pulse of a 6-pulse burst. Required: all outputs 0 immediately and no strobe. A burst applied after release reports its own count correctly.
